// File: rtl/io_hub_pkg.sv
// Shared io_hub definitions: UART bit-FSM encoding, byte-lane type and the
// command codes consumed by the downstream io_hub command state machine.
package io_hub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } bit_state_e;

  typedef logic [1:0] lane_t;

  localparam logic [7:0] CMD_START      = 8'd1;
  localparam logic [7:0] CMD_FINISH     = 8'd2;
  localparam logic [7:0] CMD_ADDR_FIRST = 8'd3;
  localparam logic [7:0] CMD_ADDR_END   = 8'd4;
  localparam logic [7:0] CMD_DATA       = 8'd5;

endpackage

// File: rtl/io_uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, bit FSM and baud counter.
// byte_valid / frame_err are combinational strobes in the stop-sample cycle.
module io_uart_rx_byte
  import io_hub_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output bit_state_e state
);

  // The counter loads 0 in the cycle after T0, hence the -1 on both compares.
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);

  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bit_idx, bit_nxt;
  logic [7:0]  shreg, sh_nxt;
  bit_state_e  state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= sh_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 16'd1;
    bit_nxt    = bit_idx;
    sh_nxt     = shreg;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (rx_prev && !rx_s2) state_nxt = ST_START;
      end
      ST_START: begin
        if (cnt == HALF_M1) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_s2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == DIV_M1) begin
          cnt_nxt = '0;
          sh_nxt  = {rx_s2, shreg[7:1]};
          bit_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt == DIV_M1) begin
          cnt_nxt = '0;
          if (rx_s2) begin
            byte_valid = 1'b1;
            state_nxt  = ST_IDLE;
          end else begin
            frame_err = 1'b1;
            state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_nxt = '0;
        if (rx_s2) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign byte_data = shreg;

endmodule

// File: rtl/io_uart_word_rx.sv
// UART word receiver: assembles four 8N1 bytes into a little-endian 32-bit
// word; framing errors and inter-byte timeouts drop the partial word.
module io_uart_word_rx
  import io_hub_pkg::*;
#(
  parameter int CLK_DIV      = 434,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] data,
  output logic        data_ready,
  output logic        frame_err,
  output logic        timeout_err
);

  localparam int TLIM_I = TIMEOUT_BITS * CLK_DIV;
  localparam int TW     = $clog2(TLIM_I + 1);
  localparam logic [TW-1:0] TLIM = TW'(TLIM_I);

  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ferr;
  bit_state_e    bit_state;
  lane_t         byte_cnt;
  logic [23:0]   shadow;
  logic [TW-1:0] tcnt;

  io_uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_byte (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (byte_ferr),
    .state      (bit_state)
  );

  // Acceptance outranks timeout expiry; byte 3 goes straight into data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data        <= '0;
      data_ready  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      byte_cnt    <= '0;
      shadow      <= '0;
      tcnt        <= '0;
    end else begin
      data_ready  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      if (byte_valid) begin
        tcnt     <= '0;
        byte_cnt <= byte_cnt + 1'b1;
        case (byte_cnt)
          2'd0: shadow[7:0]   <= byte_data;
          2'd1: shadow[15:8]  <= byte_data;
          2'd2: shadow[23:16] <= byte_data;
          default: begin
            data       <= {byte_data, shadow};
            data_ready <= 1'b1;
            shadow     <= '0;
          end
        endcase
      end else if (byte_ferr) begin
        frame_err <= 1'b1;
        byte_cnt  <= '0;
        shadow    <= '0;
        tcnt      <= '0;
      end else if (bit_state != ST_IDLE || byte_cnt == 2'd0) begin
        tcnt <= '0;
      end else if (tcnt == TLIM) begin
        timeout_err <= 1'b1;
        byte_cnt    <= '0;
        shadow      <= '0;
        tcnt        <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_uart_word_rx.sv
// Bench for io_uart_word_rx: directed scenarios plus randomized byte streams,
// checked against a byte-level word-assembly model and strobe latency rules.
module tb_io_uart_word_rx;
  import io_hub_pkg::*;

  localparam int DIV    = 16;
  localparam int TOBITS = 12;
  localparam int LAT    = 2 + DIV / 2 + 9 * DIV + 1;
  localparam int TO_GAP = 260;

  logic        clk, rst, rx;
  logic [31:0] data;
  logic        data_ready, frame_err, timeout_err;

  io_uart_word_rx #(.CLK_DIV(DIV), .TIMEOUT_BITS(TOBITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .data        (data),
    .data_ready  (data_ready),
    .frame_err   (frame_err),
    .timeout_err (timeout_err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] part_w, last_word;
  int part_n, exp_dr, exp_fe, exp_to;
  int n_dr, n_fe, n_to;
  int n_checks, n_fail;
  int last_start;
  logic prev_dr, prev_fe, prev_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // monitor: strobe latency, width and word content
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_dr) check("dr_width", 32'(data_ready), 32'd0);
      if (prev_fe) check("fe_width", 32'(frame_err), 32'd0);
      if (prev_to) check("to_width", 32'(timeout_err), 32'd0);
      if (data_ready) begin
        n_dr++;
        check("dr_latency", 32'(cyc - last_start), 32'(LAT));
        check("dr_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("word", data, exp_q.pop_front());
      end
      if (frame_err) begin
        n_fe++;
        check("fe_latency", 32'(cyc - last_start), 32'(LAT));
      end
      if (timeout_err) n_to++;
    end
    prev_dr = data_ready;
    prev_fe = frame_err;
    prev_to = timeout_err;
  end

  // driver tasks (entered and left at a negedge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    if (n >= TO_GAP && part_n != 0) begin
      exp_to++;
      part_n = 0;
      part_w = '0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) begin
      part_w[part_n*8 +: 8] = b;
      part_n++;
      if (part_n == 4) begin
        exp_q.push_back(part_w);
        exp_dr++;
        last_word = part_w;
        part_n = 0;
        part_w = '0;
      end
    end else begin
      exp_fe++;
      part_n = 0;
      part_w = '0;
    end
    rx = 1'b0;
    last_start = cyc;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop_ok;
    repeat (DIV) @(negedge clk);
    if (!stop_ok) begin
      repeat (40) @(negedge clk);
      rx = 1'b1;
      repeat (4) @(negedge clk);
    end
    check("data_hold", data, last_word);
    check("byte_cnt", 32'(dut.byte_cnt), 32'(part_n));
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_dr"}, 32'(n_dr), 32'(exp_dr));
    check({tag, "_fe"}, 32'(n_fe), 32'(exp_fe));
    check({tag, "_to"}, 32'(n_to), 32'(exp_to));
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    part_w = '0; last_word = '0; part_n = 0;
    exp_dr = 0; exp_fe = 0; exp_to = 0;
    n_dr = 0; n_fe = 0; n_to = 0;
    n_checks = 0; n_fail = 0; last_start = 0;
    prev_dr = 1'b0; prev_fe = 1'b0; prev_to = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_data", data, 32'd0);
    check("rst_strobes", {29'd0, data_ready, frame_err, timeout_err}, 32'd0);
    check("rst_fsm", 32'(dut.u_byte.state), 32'(ST_IDLE));
    check("rst_byte_cnt", 32'(dut.byte_cnt), 32'd0);
    rst = 1'b0;
    idle(5);

    // single word, data holds afterwards
    send_word(32'h0000_0003);
    idle(30);
    check("hold_after", data, 32'h0000_0003);
    check_counts("t1");

    // two words back-to-back
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    check_counts("t2");

    // timeout on a partial word, then a clean word
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(TO_GAP);
    check("to_byte_cnt", 32'(dut.byte_cnt), 32'd0);
    send_word(32'h1122_3344);
    check_counts("t3");

    // framing error with a held break
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b0);
    send_word(32'hCAFE_F00D);
    check_counts("t4");

    // short glitch while idle with two bytes pending
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    idle(20);
    check("glitch_fsm", 32'(dut.u_byte.state), 32'(ST_IDLE));
    check("glitch_byte_cnt", 32'(dut.byte_cnt), 32'd2);
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    check_counts("t5");

    // reset during bit 3 of byte 2
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(i & 1);
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
    repeat (DIV / 2) @(negedge clk);
    rst = 1'b1;
    part_n = 0; part_w = '0; last_word = '0;
    @(negedge clk);
    check("mid_rst_data", data, 32'd0);
    check("mid_rst_strobes", {29'd0, data_ready, frame_err, timeout_err}, 32'd0);
    check("mid_rst_fsm", 32'(dut.u_byte.state), 32'(ST_IDLE));
    check("mid_rst_byte_cnt", 32'(dut.byte_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(5);
    send_word(32'h0000_0001);
    check_counts("t6");

    // randomized stream: random bytes, gaps, timeouts and framing errors
    for (int k = 0; k < 40; k++) begin
      int r, g;
      r = $urandom_range(0, 19);
      send_byte(8'($urandom_range(0, 255)), r != 0);
      g = $urandom_range(0, 19);
      if (g == 0) idle(TO_GAP);
      else if (g < 10) idle(g);
    end
    idle(TO_GAP);
    check_counts("rand");
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_uart_word_rx.md
# io_uart_word_rx

Serial front end of the io_hub. Receives 8N1 UART bytes on a single input pin and assembles four consecutive bytes into one 32-bit little-endian word. Each completed word is presented on `data` with a one-cycle `data_ready` strobe, directly feeding the io_hub command state machine. Framing errors and inter-byte timeouts discard partial words so the downstream stage never sees a misaligned word.

## Interface
- `CLK_DIV`, 434, clock cycles per UART bit (50 MHz / 115200); legal range 8..65535.
- `TIMEOUT_BITS`, 32, idle bit periods after a byte before a partial word is discarded; legal range ≥ 12.
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-high reset.
- `rx`  input  1  UART line, asynchronous to `clk`, idle high.
- `data`  output  32  last completed word, little-endian; holds until the next word completes.
- `data_ready`  output  1  one-cycle strobe; `data` is valid in the same cycle.
- `frame_err`  output  1  one-cycle strobe on a bad stop bit.
- `timeout_err`  output  1  one-cycle strobe when a partial word is discarded by timeout.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- Bit FSM states:
  - IDLE: a falling edge of the synchronized `rx` → START, and the bit counter loads 0.
  - START: at count `CLK_DIV/2` (floor), sample the line. If low → DATA. If high (glitch) → IDLE, with no strobes.
  - DATA: every `CLK_DIV` cycles, sample one bit, LSB first, into the byte shift register. After 8 samples → STOP.
  - STOP: after `CLK_DIV` cycles, sample the line.
    - High: the byte is accepted → IDLE.
    - Low: pulse `frame_err`, clear the byte count and shadow word → BREAK.
  - BREAK: wait for the synchronized `rx` to be high → IDLE.
- Word assembly:
  - A 2-bit byte count selects the shadow-word lane. Byte 0 goes to [7:0] and byte 3 to [31:24].
  - On acceptance of byte 3, the next cycle copies the shadow word to `data`, pulses `data_ready`, and the count wraps to 0.
  - `data` changes only on word completion.
- Timeout:
  - While byte count ≠ 0 and the FSM is in IDLE, a counter increments each cycle.
  - When it reaches `TIMEOUT_BITS*CLK_DIV`: pulse `timeout_err`, clear the byte count and shadow word, and clear the counter.
  - The counter clears whenever the FSM leaves IDLE or a byte is accepted.
  - Counter width is `$clog2(TIMEOUT_BITS*CLK_DIV+1)`.
- Simultaneous events:
  - Byte acceptance and timeout expiry in the same cycle: the acceptance wins, and there is no `timeout_err`.
  - A frame error on byte 3: no `data_ready`, and `data` keeps its old value.
- Reset mid-frame: all state returns to IDLE immediately, the partial word is lost, and there are no strobes.

## Timing
- Reset values: `data`=0, `data_ready`=0, `frame_err`=0, `timeout_err`=0, FSM=IDLE, byte count=0.
- Let T0 be the cycle in which the synchronizer output first shows the start bit low (pin edge + 2 cycles).
- Start sample at T0+`CLK_DIV/2`. Data bit i (0..7) sampled at T0+`CLK_DIV/2`+(i+1)·`CLK_DIV`. Stop sample at T0+`CLK_DIV/2`+9·`CLK_DIV`.
- `data_ready` / `frame_err` are asserted in the cycle after the stop sample. `timeout_err` is asserted in the cycle after expiry.
- IDLE is re-entered immediately after a good stop sample, so a start bit arriving any time after mid-stop is caught. Back-to-back bytes at full rate need no gap.
- All strobes last exactly one cycle. There is no back-pressure: the downstream stage must take `data` on the `data_ready` cycle.

## Structure
- Shared package `io_hub_pkg`:
  - bit-FSM state encoding (IDLE, START, DATA, STOP, BREAK);
  - byte-lane count type;
  - the io_hub command codes (1 start, 2 finish, 3 addr_first, 4 addr_end, 5 data), so test benches and the downstream stage share them.
- Sub-module `io_uart_rx_byte`: synchronizer, bit FSM and baud counter. It outputs `byte[7:0]`, `byte_valid` and `frame_err`.
- The top level adds word assembly and timeout.

## Test plan
Benches use `CLK_DIV`=16 and `TIMEOUT_BITS`=12.
- Send bytes 0x03,0x00,0x00,0x00 back-to-back → one `data_ready`, `data`=0x00000003; `data` holds after the strobe.
- Send 0x78,0x56,0x34,0x12 then 0xEF,0xBE,0xAD,0xDE → two strobes, `data`=0x12345678 then 0xDEADBEEF, with no gap between frames.
- Send 0x11,0x22, stay idle 12·16 cycles → `timeout_err` pulses once; then 0x44,0x33,0x22,0x11 → `data`=0x11223344.
- Send 0xAA,0xBB, then a byte with stop bit low, hold `rx` low 40 cycles, release → `frame_err` once and no `data_ready`. A following full word assembles correctly.
- Pulse `rx` low for 4 cycles while in IDLE → no strobes, FSM back in IDLE, byte count unchanged.
- Assert `rst` during bit 3 of byte 2 → all outputs 0. The next four bytes 0x01,0x00,0x00,0x00 → `data`=0x00000001.
